wave_sweep_ctrl: RTL



---
 rtl/wave_sweep_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wave_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS generator: steps freq_ctrl between limits with a dwell per value.
// Optional step_tick output when WAVE_SWEEP_STEP_TICK_EN is defined.
module wave_sweep_ctrl #(
  parameter int unsigned FREQ_W  = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk_100kHz,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  f_lo,
  input  logic [FREQ_W-1:0]  f_hi,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         wave_sel,
  output logic [FREQ_W-1:0]  freq_ctrl,
  output logic [1:0]         sw,
  output logic               busy,
  output logic               done,
`ifdef WAVE_SWEEP_STEP_TICK_EN
  output logic               cfg_err,
  output logic               step_tick
`else
  output logic               cfg_err
`endif
);

  localparam int unsigned EXT_W = FREQ_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         mode_q, mode_d;
  logic [FREQ_W-1:0]  lo_q, lo_d, hi_q, hi_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic               dir_q, dir_d;  // 1 = stepping down
  logic [FREQ_W-1:0]  freq_d;
  logic [1:0]         sw_d;
  logic               busy_d, done_d, err_d;

  logic               cfg_ok, term, finish, accept, step_upd_c;
  logic [EXT_W-1:0]   up_sum;
  logic [FREQ_W-1:0]  up_nxt, dn_nxt;

  // Step arithmetic is one bit wider so an overshoot past f_hi clamps instead of wrapping.
  assign cfg_ok = (f_lo <= f_hi) && (f_step != '0);
  assign accept = start && !abort && cfg_ok;
  assign term   = (cnt_q == dwell_q);
  assign up_sum = EXT_W'(freq_ctrl) + EXT_W'(step_q);
  assign up_nxt = (up_sum > EXT_W'(hi_q)) ? hi_q : up_sum[FREQ_W-1:0];
  assign dn_nxt = (EXT_W'(freq_ctrl) < (EXT_W'(lo_q) + EXT_W'(step_q))) ? lo_q
                                                                        : (freq_ctrl - step_q);
  assign finish = term && (((mode_q == 2'd0) && (freq_ctrl == hi_q)) ||
                           ((mode_q == 2'd1) && (freq_ctrl == lo_q)));
  assign step_upd_c = ((state == IDLE) && accept) ||
                      ((state == RUN) && !abort && term && !finish);

  // State and datapath registers.
  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      freq_ctrl <= '0;
      sw        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      freq_ctrl <= freq_d;
      sw        <= sw_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= err_d;
    end
  end

  // Next-state logic; abort wins over start and over the terminal step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)       state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and sweep datapath.
  always_comb begin
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    freq_d  = freq_ctrl;
    sw_d    = sw;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = cfg_err;
    case (state)
      IDLE: begin
        sw_d = wave_sel;
        if (start && !abort) begin
          if (cfg_ok) begin
            mode_d  = mode;
            lo_d    = f_lo;
            hi_d    = f_hi;
            step_d  = f_step;
            dwell_d = dwell;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            dir_d   = (mode == 2'd1);
            freq_d  = (mode == 2'd1) ? f_hi : f_lo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          busy_d = 1'b0;
        end else if (!term) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            case (mode_q)
              2'd0: freq_d = up_nxt;
              2'd1: freq_d = dn_nxt;
              2'd2: freq_d = (freq_ctrl == hi_q) ? lo_q : up_nxt;
              default: begin
                // Ping-pong: reverse at an endpoint and step away so it is not repeated.
                if (!dir_q) begin
                  if (freq_ctrl == hi_q) begin
                    dir_d  = 1'b1;
                    freq_d = dn_nxt;
                  end else begin
                    freq_d = up_nxt;
                  end
                end else begin
                  if (freq_ctrl == lo_q) begin
                    dir_d  = 1'b0;
                    freq_d = up_nxt;
                  end else begin
                    freq_d = dn_nxt;
                  end
                end
              end
            endcase
          end
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

`ifdef WAVE_SWEEP_STEP_TICK_EN
  // One-cycle pulse aligned with each freq_ctrl update in RUN.
  always_ff @(posedge clk_100kHz) begin
    if (rst) step_tick <= 1'b0;
    else     step_tick <= step_upd_c;
  end
`else
  logic unused_step_upd;
  assign unused_step_upd = step_upd_c;
`endif

endmodule
